// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register-file write port between writer A (priority) and writer B (buffered in a 2-entry FIFO).
// Latency: 1 cycle from grant to the registered wr_en/wr_addr/wr_data. R0 writes are granted but never enabled.
// Backpressure: a_ready drops only on cycles where B is forced in. b_ready drops whenever the FIFO is full.
module regfile_write_arbiter #(
    parameter int REG_ADDRESS_SIZE = 3,
    parameter int REG_DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [REG_ADDRESS_SIZE-1:0] a_addr,
    input  logic [REG_DATA_WIDTH-1:0]   a_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [REG_ADDRESS_SIZE-1:0] b_addr,
    input  logic [REG_DATA_WIDTH-1:0]   b_data,
    output logic                        wr_en,
    output logic [REG_ADDRESS_SIZE-1:0] wr_addr,
    output logic [REG_DATA_WIDTH-1:0]   wr_data,
    output logic                        b_pending,
    output logic                        b_forced
);

    localparam int EW = REG_ADDRESS_SIZE + REG_DATA_WIDTH;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // FIFO storage; entries are {addr, data}
    logic [EW-1:0] mem_q [2];
    logic [EW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [3:0]    starve_q, starve_d;

    logic                        wr_en_q, wr_en_d;
    logic [REG_ADDRESS_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [REG_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic                        force_b;
    logic                        grant_a;
    logic                        grant_b;
    logic                        push;
    logic [EW-1:0]               head;
    logic [REG_ADDRESS_SIZE-1:0] g_addr;
    logic [REG_DATA_WIDTH-1:0]   g_data;

    // Arbitration and handshakes; everything is held off while reset is asserted
    always_comb begin
        b_pending = (count_q != 2'd0);
        force_b   = rst && b_pending && (starve_q == LIMIT);
        grant_b   = rst && b_pending && (force_b || !a_valid);
        grant_a   = rst && a_valid && !grant_b;
        a_ready   = rst && !force_b;
        // Full FIFO refuses a push even when its head pops this cycle
        b_ready   = rst && (count_q != 2'd2);
        b_forced  = force_b;
        push      = b_valid && b_ready;
        head      = mem_q[rd_ptr_q];
        g_addr    = grant_b ? head[EW-1:REG_DATA_WIDTH] : a_addr;
        g_data    = grant_b ? head[REG_DATA_WIDTH-1:0]  : a_data;
    end

    // FIFO pointer/count and starvation counter next state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ grant_b;
        count_d  = count_q + {1'b0, push} - {1'b0, grant_b};
        if (push) begin
            mem_d[wr_ptr_q] = {b_addr, b_data};
        end
        starve_d = starve_q;
        if (grant_b || !b_pending) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Write-port next state: a granted R0 write updates addr/data but stays disabled
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_a || grant_b) begin
            wr_en_d   = (g_addr != '0);
            wr_addr_d = g_addr;
            wr_data_d = g_data;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            starve_q  <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO data needs no reset: count gates every read of it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by randomized traffic.
// A queue-based reference model predicts the handshakes and the write port each cycle.
// Inputs are driven at negedge; outputs are sampled 1ns after each clock edge.
module tb_regfile_write_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_ready, b_ready, wr_en, b_pending, b_forced;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    regfile_write_arbiter #(
        .REG_ADDRESS_SIZE(AW),
        .REG_DATA_WIDTH  (DW),
        .STARVE_LIMIT    (LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .b_pending(b_pending),
        .b_forced (b_forced)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [AW+DW-1:0] m_q[$];
    int               m_starve = 0;
    logic             m_wen = 1'b0;
    logic [AW-1:0]    m_waddr = '0;
    logic [DW-1:0]    m_wdata = '0;
    logic             m_b_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check write port
    task automatic step(input logic r, input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        logic pend, frc, gb, ga, brdy;
        logic [AW+DW-1:0] e;
        @(negedge clk);
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        pend = (m_q.size() != 0);
        frc  = r && pend && (m_starve == LIM);
        brdy = r && (m_q.size() < 2);
        chk("a_ready", a_ready, r && !frc);
        chk("b_ready", b_ready, brdy);
        chk("b_pending", b_pending, pend);
        chk("b_forced", b_forced, frc);
        m_b_acc = bv && brdy;
        if (!r) begin
            m_q.delete();
            m_starve = 0;
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            gb = pend && (frc || !av);
            ga = av && !gb;
            m_wen = 1'b0;
            if (gb) begin
                e = m_q.pop_front();
                m_waddr = e[AW+DW-1:DW];
                m_wdata = e[DW-1:0];
                m_wen = (m_waddr != 0);
            end else if (ga) begin
                m_waddr = aa; m_wdata = ad;
                m_wen = (aa != 0);
            end
            if (m_b_acc) m_q.push_back({ba, bd});
            if (gb || !pend) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
        end
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, m_wen);
        chk("wr_addr", wr_addr, m_waddr);
        chk("wr_data", wr_data, m_wdata);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 3'd2, 8'h12, 1'b1, 3'd4, 8'h34);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_pending", b_pending, 1'b0);

        // A-only write
        step(1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, '0, '0);
        chk("a_wr_en", wr_en, 1'b1);
        chk("a_wr_addr", wr_addr, 3'd3);
        chk("a_wr_data", wr_data, 8'h5A);
        idle();
        chk("a_after", wr_en, 1'b0);

        // R0 suppression from A and from B
        step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, '0, '0);
        chk("r0a_en", wr_en, 1'b0);
        chk("r0a_addr", wr_addr, 3'd0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 3'd0, 8'h77);
        idle();
        chk("r0b_en", wr_en, 1'b0);
        chk("r0b_data", wr_data, 8'h77);
        chk("r0b_pop", b_pending, 1'b0);

        // FIFO fill while A streams; third B entry held, then starvation forces B
        step(1'b1, 1'b1, 3'd1, 8'h01, 1'b1, 3'd5, 8'h11);
        step(1'b1, 1'b1, 3'd1, 8'h02, 1'b1, 3'd6, 8'h22);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 3'd1, 8'(8'h10 + i), !m_b_acc || i == 0, 3'd7, 8'h33);
        end
        for (int i = 0; i < 4; i++) idle();

        // Idle A: push lands, then grants a cycle later
        step(1'b1, 1'b0, '0, '0, 1'b1, 3'd2, 8'h44);
        idle();
        chk("idle_en", wr_en, 1'b1);
        chk("idle_addr", wr_addr, 3'd2);
        chk("idle_data", wr_data, 8'h44);

        // Push and pop together with count 1
        step(1'b1, 1'b1, 3'd4, 8'hA0, 1'b1, 3'd3, 8'h01);
        step(1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 8'h02);
        idle();
        idle();

        // Reset with the FIFO full
        step(1'b1, 1'b1, 3'd1, 8'hB0, 1'b1, 3'd5, 8'hC1);
        step(1'b1, 1'b1, 3'd1, 8'hB1, 1'b1, 3'd6, 8'hC2);
        step(1'b0, 1'b1, 3'd1, 8'hB2, 1'b1, 3'd7, 8'hC3);
        chk("mid_rst_pend", b_pending, 1'b0);
        chk("mid_rst_en", wr_en, 1'b0);
        for (int i = 0; i < 3; i++) idle();

        // Randomized traffic with varying A load and occasional reset
        for (int blk = 0; blk < 8; blk++) begin
            int pct;
            pct = (blk % 4 == 0) ? 100 : (blk % 4 == 1) ? 85 : (blk % 4 == 2) ? 50 : 15;
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 149) != 0,
                     $urandom_range(0, 99) < pct, AW'($urandom), DW'($urandom),
                     $urandom_range(0, 2) != 0, AW'($urandom), DW'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writers.
- Requester A: pipeline writeback, priority by default.
- Requester B: multi-cycle/load unit, buffered in a 2-entry FIFO.
- Output drives the register file write port (WR/DA/data_in) with one registered write per cycle. It also enforces R0 write suppression and guarantees B cannot starve.

Parameters:
- REG_ADDRESS_SIZE, 3, width of register address.
- REG_DATA_WIDTH, 8, width of write data.
- STARVE_LIMIT, 4, consecutive cycles B's FIFO head may be denied before B is forced a grant (range 1..15).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- a_valid  input  1  A has a write.
- a_ready  output  1  A write accepted this cycle when a_valid && a_ready.
- a_addr  input  REG_ADDRESS_SIZE  A destination register.
- a_data  input  REG_DATA_WIDTH  A write data.
- b_valid  input  1  B has a write.
- b_ready  output  1  B FIFO has space.
- b_addr  input  REG_ADDRESS_SIZE  B destination register.
- b_data  input  REG_DATA_WIDTH  B write data.
- wr_en  output  1  register file write enable (WR), registered.
- wr_addr  output  REG_ADDRESS_SIZE  register file DA, registered.
- wr_data  output  REG_DATA_WIDTH  register file data_in, registered.
- b_pending  output  1  B FIFO non-empty.
- b_forced  output  1  current cycle's grant goes to B due to starvation.

Behaviour:
- Reset (rst==0 at posedge):
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO emptied (rd/wr pointers and count = 0).
  - Starve counter = 0, b_forced=0.
  - While rst==0: a_ready=0 and b_ready=0 combinationally. No handshake completes and a B write presented during reset is not captured.
- B FIFO:
  - 2 entries, storing {addr, data}.
  - b_ready = rst && count<2. Not dependent on same-cycle pop, so a full FIFO does not accept even if popping.
  - Push on b_valid && b_ready.
  - Pop when head is granted.
  - Simultaneous push and pop with count 1 or 2 leaves count unchanged. Push into an empty FIFO is not grantable until the next cycle (no bypass).
- Arbitration (combinational each cycle, rst==1):
  - force = (starve_cnt == STARVE_LIMIT) && b_pending.
  - Grant B if force, or if !a_valid && b_pending.
  - Otherwise grant A if a_valid.
  - a_ready = rst && !force. A is accepted whenever not forced out.
  - b_forced = force.
- Starve counter:
  - Increments when b_pending and B is not granted.
  - Clears to 0 when B is granted or FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Write port (registered, latency 1): on posedge after a grant, wr_addr/wr_data take the granted addr/data.
  - wr_en=1 iff a grant occurred and granted addr != 0.
  - Writes to address 0 complete their handshake or pop but produce wr_en=0. wr_addr/wr_data still update.
  - No grant leaves wr_en=0 and wr_addr/wr_data holding their previous values.
- Ordering:
  - Writes reach the port strictly in grant order.
  - Same-address A and B in flight: the later grant overwrites.
  - B-to-B order is preserved by the FIFO.
- Reset mid-operation: FIFO contents discarded, and wr_en=0 on the cycle after the reset edge.
- Throughput: at most one write per cycle; A sees back-pressure only on forced cycles.

Test Plan:
- Reset, then A-only: a_valid=1, a_addr=3, a_data=0x5A for 1 cycle -> a_ready=1. Next cycle wr_en=1, wr_addr=3, wr_data=0x5A. Following cycle wr_en=0.
- R0 suppression: A writes addr 0, data 0xFF -> a_ready=1, next cycle wr_en=0, wr_addr=0. Same from B -> FIFO pops, wr_en=0.
- FIFO fill: a_valid=1 continuously, B pushes (5,0x11), (6,0x22), then (7,0x33).
  - The third is held: b_ready=0 while count==2.
  - After 4 denied cycles b_forced=1 and a_ready=0 for one cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x11.
- Idle A: b pushes (2,0x44) with a_valid=0 -> head grantable next cycle, write (2,0x44) one cycle later; b_pending falls.
- Simultaneous push/pop with count=1 -> count stays 1, entry order preserved (older written first).
- Reset mid-operation: FIFO holding 2 entries, assert rst=0 for one cycle -> b_pending=0, wr_en=0, a_ready=b_ready=0 during reset. After release no stale B writes appear.
